// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the masked single-port SRAM model.
package sram_pkg;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef enum logic [0:0] {
    INIT  = ST_INIT,
    READY = ST_READY
  } state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit segs_ok(input int unsigned width, input int unsigned segs);
    return (segs != 0) && ((width % segs) == 0);
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Clear-on-reset sequencer: walks every entry once, then opens the request port.
//  state | meaning
//  INIT  | writing zero to entry cnt_q, requests ignored
//  READY | array cleared, requests accepted every cycle
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          req_ready_o,
  output logic          init_done_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == LAST) begin
        state_d = READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
    init_done_d = (state_d == READY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign clr_we_o    = (state_q == INIT);
  assign clr_addr_o  = cnt_q;
  assign req_ready_o = (state_q == READY);
  assign init_done_o = init_done_q;

endmodule

// File: rtl/sram_sp_masked_init.sv
// Single-port segment-masked SRAM with hardware clear, valid/ready port and
// optional hold of the last read data.
module sram_sp_masked_init
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WIDTH      = 1044,
  parameter int unsigned SEGS       = 4,
  parameter bit          HOLD_RDATA = 1'b1,
  localparam int unsigned AW        = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wmode,
  input  logic [AW-1:0]    req_addr,
  input  logic [SEGS-1:0]  req_wmask,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             init_done
);

  localparam int unsigned SEG_W = WIDTH / SEGS;

  if (!segs_ok(WIDTH, SEGS)) begin : g_bad_segs
    $error("sram_sp_masked_init: WIDTH must be a multiple of SEGS");
  end

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             fire, wr_fire, rd_fire, in_range;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rvalid_q;
  logic [WIDTH-1:0] rdata_q;

  sram_init_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_ctrl (
    .clock       (clock),
    .reset_n     (reset_n),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .req_ready_o (req_ready),
    .init_done_o (init_done)
  );

  assign fire     = req_valid & req_ready;
  assign wr_fire  = fire & req_wmode;
  assign rd_fire  = fire & ~req_wmode;
  assign in_range = (32'(req_addr) < DEPTH);

  // Contents are intentionally not reset; the clear sequencer defines them.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_fire && in_range) begin
      for (int s = 0; s < SEGS; s++) begin
        if (req_wmask[s]) begin
          mem_q[req_addr][s*SEG_W +: SEG_W] <= req_wdata[s*SEG_W +: SEG_W];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) begin
        rdata_q <= in_range ? mem_q[req_addr] : '0;
      end
    end
  end

  assign resp_valid = rvalid_q;
  assign resp_rdata = (HOLD_RDATA || rvalid_q) ? rdata_q : '0;

endmodule
